regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the CPU core, successor to the current 2-read/1-write design.
- Configurable data width, register count, read ports and write ports.
- Registered reads with optional same-cycle write forwarding, a PC shadow register updated every cycle, and a per-register busy scoreboard for outstanding loads.
- Sits between decode (read addresses) and writeback (write ports), and feeds operands to execute.

Parameters:
- DATA_W, 32, register data width
- NUM_REGS, 16, number of architectural registers (power of two, ≥4)
- N_RD, 3, number of read ports
- N_WR, 2, number of write ports
- PC_IDX, 15, index of the program-counter register
- SP_IDX, 13, index of the stack pointer
- SP_RESET, 32'h0, reset value of the SP register
- FWD, 1, 1 = a read sees same-cycle writes; 0 = read-before-write

Ports (AW = $clog2(NUM_REGS)):
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_addr_r  in  N_RD×AW  read addresses
- i_stall  in  1  hold read outputs; writes, PC update and scoreboard still proceed
- o_rdata  out  N_RD×DATA_W  registered read data
- o_rd_busy  out  N_RD  registered busy flag of each read address
- i_addr_w  in  N_WR×AW  write addresses
- i_wdata  in  N_WR×DATA_W  write data
- i_wr_en  in  N_WR  write enables
- i_pc  in  DATA_W  current PC from fetch
- o_pc_r  out  DATA_W  stored PC register value
- i_lock_en  in  1  mark a register busy (load issued)
- i_lock_addr  in  AW  register to mark busy
- o_busy  out  NUM_REGS  scoreboard vector

Behaviour:
- Reset (async assert; deassert is synchronised externally):
  - all registers 0, except regs[SP_IDX] = SP_RESET
  - o_rdata = 0, o_rd_busy = 0, busy vector = 0
- PC shadow:
  - every non-reset cycle, regs[PC_IDX] <= i_pc
  - an enabled write port targeting PC_IDX overrides i_pc (branch writeback)
  - o_pc_r is combinational from regs[PC_IDX]
- Writes:
  - each enabled port writes i_wdata[j] to regs[i_addr_w[j]] at the clock edge
  - same-address conflict: the highest-numbered enabled port wins
- Reads (1-cycle latency; data captured at edge t, visible after it). Per port k, selection priority:
  1. i_addr_r[k]==PC_IDX: i_pc
  2. FWD=1 and any enabled write port hits the address: that port's i_wdata, highest-numbered port winning
  3. otherwise regs[i_addr_r[k]] (pre-edge value)
- Stall: i_stall=1 holds o_rdata and o_rd_busy unchanged; register writes, the PC update and busy updates still occur.
- Scoreboard:
  - i_lock_en sets busy[i_lock_addr]
  - any enabled write to address a clears busy[a]
  - simultaneous set and clear on the same address: set wins
  - lock of PC_IDX is ignored (busy[PC_IDX] stays 0)
- o_rd_busy[k]:
  - registered alongside o_rdata
  - equals the post-update busy of i_addr_r[k] when FWD=1
  - equals the pre-update busy when FWD=0
  - always 0 for PC_IDX
- o_busy is combinational from the busy flops.
- Reset mid-operation: all state is cleared immediately, independent of clk; pending locks are lost.
- Out-of-range addresses cannot occur (NUM_REGS is a power of two).

Decomposition:
- Shared package cpu_pkg holds:
  - the SP/LR/PC index localparams (13/14/15), replacing per-module copies
  - typedef reg_addr_t = logic [3:0]
  - typedef word_t = logic [31:0]
- One sub-module, regfile_fwd_mux: a combinational per-port priority select (PC / forward / array), instantiated N_RD times via generate.
- The scoreboard stays inline.

Test Plan:
- Reset: assert rst mid-cycle with SP_RESET=32'h2000_0000 → o_rdata=0 immediately; after release, reading r13 gives 32'h2000_0000 and r0 gives 0.
- Write then read: write r3=32'hDEAD_BEEF on port 0 at cycle 1, read r3 at cycle 2 → o_rdata=32'hDEAD_BEEF at cycle 3.
- Same-cycle forwarding and conflict: in one cycle, port0 writes r5=32'h1111 and port1 writes r5=32'h2222, while r5 is read.
  - FWD=1 → read returns 32'h2222 and regs[5]=32'h2222.
  - FWD=0 → read returns the old value 0.
- PC handling: i_pc=32'h100 with a read of r15 → o_rdata=32'h100 and o_pc_r=32'h100 next cycle. Writing r15=32'h400 in the same cycle as i_pc=32'h104 → o_pc_r=32'h400.
- Scoreboard:
  - lock r7 → o_busy[7]=1
  - read r7 → o_rd_busy=1
  - write r7 while locking r7 in the same cycle → busy stays 1
  - a later write without lock → busy=0
- Stall: hold i_stall=1 for 3 cycles while changing i_addr_r and writing r2=32'h55 → o_rdata frozen. Release → the r2 read returns 32'h55.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU core definitions: architectural register indices and common word/address types.
package cpu_pkg;

  localparam int SP_REG = 13;
  localparam int LR_REG = 14;
  localparam int PC_REG = 15;

  typedef logic [3:0]  reg_addr_t;
  typedef logic [31:0] word_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the multi-port register file.
interface regfile_mp_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int N_RD     = 3,
  parameter int N_WR     = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic [N_RD-1:0][AW-1:0]     i_addr_r;
  logic                        i_stall;
  logic [N_RD-1:0][DATA_W-1:0] o_rdata;
  logic [N_RD-1:0]             o_rd_busy;
  logic [N_WR-1:0][AW-1:0]     i_addr_w;
  logic [N_WR-1:0][DATA_W-1:0] i_wdata;
  logic [N_WR-1:0]             i_wr_en;
  logic [DATA_W-1:0]           i_pc;
  logic [DATA_W-1:0]           o_pc_r;
  logic                        i_lock_en;
  logic [AW-1:0]               i_lock_addr;
  logic [NUM_REGS-1:0]         o_busy;

  modport master (
    output i_addr_r, i_stall, i_addr_w, i_wdata, i_wr_en, i_pc, i_lock_en, i_lock_addr,
    input  o_rdata, o_rd_busy, o_pc_r, o_busy
  );

  modport slave (
    input  i_addr_r, i_stall, i_addr_w, i_wdata, i_wr_en, i_pc, i_lock_en, i_lock_addr,
    output o_rdata, o_rd_busy, o_pc_r, o_busy
  );

endinterface

// File: rtl/regfile_fwd_mux.sv
// Per-read-port operand select: PC first, then same-cycle write forwarding, then the array.
module regfile_fwd_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int N_WR     = 2,
  parameter int PC_IDX   = PC_REG,
  parameter bit FWD      = 1'b1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic [AW-1:0]               addr_i,
  input  logic [DATA_W-1:0]           pc_i,
  input  logic [DATA_W-1:0]           arr_i,
  input  logic [N_WR-1:0]             wr_en_i,
  input  logic [N_WR-1:0][AW-1:0]     addr_w_i,
  input  logic [N_WR-1:0][DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0]           data_o
);

  localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

  // Later assignments override earlier ones, so the highest write port wins and PC wins overall.
  always_comb begin
    data_o = arr_i;
    if (FWD) begin
      for (int j = 0; j < N_WR; j++) begin
        if (wr_en_i[j] && (addr_w_i[j] == addr_i)) data_o = wdata_i[j];
      end
    end
    if (addr_i == PC_A) data_o = pc_i;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads, PC shadow register and load busy scoreboard.
module regfile_mp
  import cpu_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              NUM_REGS = 16,
  parameter int              N_RD     = 3,
  parameter int              N_WR     = 2,
  parameter int              PC_IDX   = PC_REG,
  parameter int              SP_IDX   = SP_REG,
  parameter logic [DATA_W-1:0] SP_RESET = '0,
  parameter bit              FWD      = 1'b1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int            AW   = $clog2(NUM_REGS);
  localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

  logic [DATA_W-1:0]           regs_q [NUM_REGS];
  logic [DATA_W-1:0]           regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]         busy_q, busy_d;
  logic [N_RD-1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic [N_RD-1:0]             rd_busy_q, rd_busy_d;

  // Architectural state next-state: PC shadow, then write ports in ascending priority.
  always_comb begin
    regs_d         = regs_q;
    busy_d         = busy_q;
    regs_d[PC_IDX] = bus.i_pc;
    for (int j = 0; j < N_WR; j++) begin
      if (bus.i_wr_en[j]) begin
        regs_d[bus.i_addr_w[j]] = bus.i_wdata[j];
        busy_d[bus.i_addr_w[j]] = 1'b0;
      end
    end
    if (bus.i_lock_en && (bus.i_lock_addr != PC_A)) busy_d[bus.i_lock_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read stage: operand select per port, registered once.
  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    regfile_fwd_mux #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .N_WR     (N_WR),
      .PC_IDX   (PC_IDX),
      .FWD      (FWD)
    ) u_mux (
      .addr_i   (bus.i_addr_r[k]),
      .pc_i     (bus.i_pc),
      .arr_i    (regs_q[bus.i_addr_r[k]]),
      .wr_en_i  (bus.i_wr_en),
      .addr_w_i (bus.i_addr_w),
      .wdata_i  (bus.i_wdata),
      .data_o   (rdata_d[k])
    );

    // With forwarding the reader sees this cycle's lock/clear; without it, the flop value.
    assign rd_busy_d[k] = (bus.i_addr_r[k] == PC_A) ? 1'b0 :
                          (FWD ? busy_d[bus.i_addr_r[k]] : busy_q[bus.i_addr_r[k]]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q   <= '0;
      rd_busy_q <= '0;
    end else if (!bus.i_stall) begin
      rdata_q   <= rdata_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign bus.o_rdata   = rdata_q;
  assign bus.o_rd_busy = rd_busy_q;
  assign bus.o_pc_r    = regs_q[PC_IDX];
  assign bus.o_busy    = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a forwarding and a non-forwarding instance share stimulus and a reference model.
module tb_regfile_mp;
  import cpu_pkg::*;

  localparam word_t SPR = 32'h2000_0000;

  logic clk, rst;
  logic [2:0][3:0]  addr_r;
  logic             stall;
  logic [1:0][3:0]  addr_w;
  logic [1:0][31:0] wdata;
  logic [1:0]       wr_en;
  logic [31:0]      pc;
  logic             lock_en;
  logic [3:0]       lock_addr;
  logic             chk_on;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_mp_if #(.DATA_W(32), .NUM_REGS(16), .N_RD(3), .N_WR(2)) ifa ();
  regfile_mp_if #(.DATA_W(32), .NUM_REGS(16), .N_RD(3), .N_WR(2)) ifb ();

  assign ifa.i_addr_r = addr_r;    assign ifb.i_addr_r = addr_r;
  assign ifa.i_stall = stall;      assign ifb.i_stall = stall;
  assign ifa.i_addr_w = addr_w;    assign ifb.i_addr_w = addr_w;
  assign ifa.i_wdata = wdata;      assign ifb.i_wdata = wdata;
  assign ifa.i_wr_en = wr_en;      assign ifb.i_wr_en = wr_en;
  assign ifa.i_pc = pc;            assign ifb.i_pc = pc;
  assign ifa.i_lock_en = lock_en;  assign ifb.i_lock_en = lock_en;
  assign ifa.i_lock_addr = lock_addr; assign ifb.i_lock_addr = lock_addr;

  regfile_mp #(.SP_RESET(SPR), .FWD(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  regfile_mp #(.SP_RESET(SPR), .FWD(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input word_t act, input word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents, busy set, and per-instance registered read outputs.
  word_t       m_regs [16];
  logic [15:0] m_busy;
  word_t       m_rd   [2][3];
  logic        m_rdb  [2][3];
  logic [15:0] nb;
  word_t       d;
  logic [3:0]  a;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_regs[i] = (i == 13) ? SPR : 32'h0;
      m_busy = '0;
      for (int f = 0; f < 2; f++)
        for (int k = 0; k < 3; k++) begin m_rd[f][k] = '0; m_rdb[f][k] = 1'b0; end
    end else begin
      nb = m_busy;
      for (int j = 0; j < 2; j++) if (wr_en[j]) nb[addr_w[j]] = 1'b0;
      if (lock_en && lock_addr != 4'd15) nb[lock_addr] = 1'b1;
      if (!stall) begin
        for (int f = 0; f < 2; f++) begin
          for (int k = 0; k < 3; k++) begin
            a = addr_r[k];
            d = m_regs[a];
            if (f == 0) for (int j = 0; j < 2; j++) if (wr_en[j] && addr_w[j] == a) d = wdata[j];
            if (a == 4'd15) d = pc;
            m_rd[f][k]  = d;
            m_rdb[f][k] = (a == 4'd15) ? 1'b0 : ((f == 0) ? nb[a] : m_busy[a]);
          end
        end
      end
      m_regs[15] = pc;
      for (int j = 0; j < 2; j++) if (wr_en[j]) m_regs[addr_w[j]] = wdata[j];
      m_busy = nb;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("A.rdata%0d", k), ifa.o_rdata[k], m_rd[0][k]);
        check($sformatf("B.rdata%0d", k), ifb.o_rdata[k], m_rd[1][k]);
        check($sformatf("A.rd_busy%0d", k), 32'(ifa.o_rd_busy[k]), 32'(m_rdb[0][k]));
        check($sformatf("B.rd_busy%0d", k), 32'(ifb.o_rd_busy[k]), 32'(m_rdb[1][k]));
      end
      check("A.pc_r", ifa.o_pc_r, m_regs[15]);
      check("B.pc_r", ifb.o_pc_r, m_regs[15]);
      check("A.busy", 32'(ifa.o_busy), 32'(m_busy));
      check("B.busy", 32'(ifb.o_busy), 32'(m_busy));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; wr_en = '0; lock_en = 1'b0;
  endtask

  initial begin
    chk_on = 1'b0;
    rst = 1'b1;
    addr_r = '0; stall = 1'b0; addr_w = '0; wdata = '0; wr_en = '0;
    pc = '0; lock_en = 1'b0; lock_addr = '0;
    tick(); tick();
    chk_on = 1'b1;
    check("rst.rdata0", ifa.o_rdata[0], 32'h0);
    check("rst.busy", 32'(ifa.o_busy), 32'h0);

    // Reset values visible through the read path
    rst = 1'b0;
    addr_r[0] = 4'd13; addr_r[1] = 4'd0; addr_r[2] = 4'd1;
    tick();
    check("sp_reset.A", ifa.o_rdata[0], SPR);
    check("sp_reset.B", ifb.o_rdata[0], SPR);
    check("r0_reset", ifa.o_rdata[1], 32'h0);

    // Write then read
    wr_en = 2'b01; addr_w[0] = 4'd3; wdata[0] = 32'hDEAD_BEEF; addr_r[0] = 4'd0;
    tick();
    idle(); addr_r[0] = 4'd3;
    tick();
    check("wr_rd.A", ifa.o_rdata[0], 32'hDEAD_BEEF);
    check("wr_rd.B", ifb.o_rdata[0], 32'hDEAD_BEEF);

    // Same-cycle conflict on r5 while reading it
    wr_en = 2'b11; addr_w[0] = 4'd5; addr_w[1] = 4'd5;
    wdata[0] = 32'h1111; wdata[1] = 32'h2222; addr_r[0] = 4'd5;
    tick();
    check("fwd.A", ifa.o_rdata[0], 32'h2222);
    check("nofwd.B", ifb.o_rdata[0], 32'h0);
    idle();
    tick();
    check("conflict_reg.B", ifb.o_rdata[0], 32'h2222);

    // PC shadow and branch writeback override
    pc = 32'h100; addr_r[0] = 4'd15;
    tick();
    check("pc_read", ifa.o_rdata[0], 32'h100);
    check("pc_r", ifa.o_pc_r, 32'h100);
    pc = 32'h104; wr_en = 2'b01; addr_w[0] = 4'd15; wdata[0] = 32'h400;
    tick();
    check("pc_branch", ifa.o_pc_r, 32'h400);
    check("pc_read_prio", ifa.o_rdata[0], 32'h104);
    idle();

    // Scoreboard
    lock_en = 1'b1; lock_addr = 4'd7; addr_r[0] = 4'd0;
    tick();
    check("lock7", 32'(ifa.o_busy[7]), 32'h1);
    lock_en = 1'b0; addr_r[0] = 4'd7;
    tick();
    check("rd_busy7.A", 32'(ifa.o_rd_busy[0]), 32'h1);
    wr_en = 2'b01; addr_w[0] = 4'd7; wdata[0] = 32'h77; lock_en = 1'b1;
    tick();
    check("lock_wins", 32'(ifa.o_busy[7]), 32'h1);
    lock_en = 1'b0;
    tick();
    check("clear7", 32'(ifa.o_busy[7]), 32'h0);
    check("rd_busy_post.A", 32'(ifa.o_rd_busy[0]), 32'h0);
    check("rd_busy_pre.B", 32'(ifb.o_rd_busy[0]), 32'h1);
    wr_en = '0; lock_en = 1'b1; lock_addr = 4'd15;
    tick();
    check("lock_pc", 32'(ifa.o_busy[15]), 32'h0);
    idle();

    // Stall freezes outputs while writes proceed
    addr_r[0] = 4'd3;
    tick();
    stall = 1'b1; addr_r[0] = 4'd5; wr_en = 2'b01; addr_w[0] = 4'd2; wdata[0] = 32'h55;
    tick();
    check("stall1", ifa.o_rdata[0], 32'hDEAD_BEEF);
    wr_en = '0; addr_r[0] = 4'd2;
    tick();
    check("stall2", ifa.o_rdata[0], 32'hDEAD_BEEF);
    addr_r[0] = 4'd7;
    tick();
    check("stall3", ifa.o_rdata[0], 32'hDEAD_BEEF);
    stall = 1'b0; addr_r[0] = 4'd2;
    tick();
    check("stall_release", ifa.o_rdata[0], 32'h55);

    // Asynchronous reset in mid-cycle
    lock_en = 1'b1; lock_addr = 4'd4;
    tick();
    lock_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rdata", ifa.o_rdata[0], 32'h0);
    check("async_busy", 32'(ifa.o_busy), 32'h0);
    check("async_pc", ifa.o_pc_r, 32'h0);
    tick();
    rst = 1'b0; addr_r[0] = 4'd13; addr_r[1] = 4'd0;
    tick();
    check("post_rst_sp", ifa.o_rdata[0], SPR);
    check("post_rst_r0", ifa.o_rdata[1], 32'h0);

    // Randomised traffic checked every cycle against the model
    for (int n = 0; n < 2000; n++) begin
      stall = ($urandom_range(0, 4) == 0);
      for (int k = 0; k < 3; k++) addr_r[k] = 4'($urandom_range(0, 15));
      for (int j = 0; j < 2; j++) begin
        addr_w[j] = 4'($urandom_range(0, 15));
        wdata[j]  = $urandom;
      end
      if ($urandom_range(0, 3) == 0) addr_w[1] = addr_w[0];
      if ($urandom_range(0, 3) == 0) addr_r[0] = addr_w[$urandom_range(0, 1)];
      wr_en     = 2'($urandom_range(0, 3));
      pc        = $urandom;
      lock_en   = ($urandom_range(0, 2) == 0);
      lock_addr = ($urandom_range(0, 2) == 0) ? addr_w[0] : 4'($urandom_range(0, 15));
      tick();
    end
    idle();
    tick();
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
